// File: rtl/regfile_pkg.sv
// Shared types and limits for the multi-port register file.
//   reg_addr_t / reg_data_t : default-width address and data types.
//   ZERO_REG                : index of the hardwired-zero register.
//   MAX_RD_PORTS/MAX_WR_PORTS : port-count limits, checked at elaboration.
package regfile_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  localparam int unsigned ZERO_REG     = 0;
  localparam int unsigned MAX_RD_PORTS = 4;
  localparam int unsigned MAX_WR_PORTS = 3;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an outstanding write.
// Ports:
//   clk, rst_n   : clock, async active-low reset (clears all busy bits)
//   rsv_en_i     : reserve rsv_addr_i (sets its busy bit on the next edge)
//   rsv_addr_i   : register to reserve
//   clr_vec_i    : per-register clear request from this cycle's writes
//   rd_addr_i    : per-read-port lookup addresses
//   rd_busy_o    : registered busy bit of each looked-up register
//   busy_vec_o   : full registered busy vector
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REG_MEM_ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD_PORTS       = 2
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            rsv_en_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0]                   rsv_addr_i,
  input  logic [2**REG_MEM_ADDR_WIDTH-1:0]                clr_vec_i,
  input  logic [NUM_RD_PORTS-1:0][REG_MEM_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS-1:0]                         rd_busy_o,
  output logic [2**REG_MEM_ADDR_WIDTH-1:0]                busy_vec_o
);

  localparam logic [REG_MEM_ADDR_WIDTH-1:0] ZeroAddr = REG_MEM_ADDR_WIDTH'(ZERO_REG);

  logic [2**REG_MEM_ADDR_WIDTH-1:0] busy_d, busy_q;

  // Reserve is applied after the clear so a same-cycle reserve wins: the
  // newer instruction owns the register.
  always_comb begin
    busy_d = busy_q & ~clr_vec_i;
    if (rsv_en_i) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[ZeroAddr] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      rd_busy_o[p] = busy_q[rd_addr_i[p]];
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Register 0 is hardwired to zero. Higher-index write ports win conflicts.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes to
// the read ports (data returned, busy masked); otherwise reads see stored
// state only.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   rd_addr_i/rd_data_o : combinational read ports
//   rd_busy_o           : busy flag of each read port's register
//   wr_en_i/wr_addr_i/wr_data_i : writeback ports
//   rsv_en_i/rsv_addr_i : destination reservation at issue
//   busy_vec_o          : registered busy bits (no bypass)
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned REG_MEM_ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD_PORTS       = 2,
  parameter int unsigned NUM_WR_PORTS       = 2
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_RD_PORTS-1:0][REG_MEM_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]         rd_data_o,
  output logic [NUM_RD_PORTS-1:0]                         rd_busy_o,
  input  logic [NUM_WR_PORTS-1:0]                         wr_en_i,
  input  logic [NUM_WR_PORTS-1:0][REG_MEM_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0]         wr_data_i,
  input  logic                                            rsv_en_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0]                   rsv_addr_i,
  output logic [2**REG_MEM_ADDR_WIDTH-1:0]                busy_vec_o
);

  localparam int unsigned NumRegs = 2**REG_MEM_ADDR_WIDTH;
  localparam logic [REG_MEM_ADDR_WIDTH-1:0] ZeroAddr = REG_MEM_ADDR_WIDTH'(ZERO_REG);

  if (NUM_RD_PORTS < 1 || NUM_RD_PORTS > MAX_RD_PORTS) begin : g_bad_rd_ports
    $error("register_file_mp: NUM_RD_PORTS out of range");
  end
  if (NUM_WR_PORTS < 1 || NUM_WR_PORTS > MAX_WR_PORTS) begin : g_bad_wr_ports
    $error("register_file_mp: NUM_WR_PORTS out of range");
  end

  logic [NumRegs-1:0][DATA_WIDTH-1:0] mem_d, mem_q;
  logic [NumRegs-1:0]                 clr_vec;
  logic [NUM_RD_PORTS-1:0]            sb_busy;

  // Later (higher-index) ports overwrite earlier ones, giving them priority.
  always_comb begin
    mem_d   = mem_q;
    clr_vec = '0;
    for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
      if (wr_en_i[w] && (wr_addr_i[w] != ZeroAddr)) begin
        mem_d[wr_addr_i[w]]   = wr_data_i[w];
        clr_vec[wr_addr_i[w]] = 1'b1;
      end
    end
    mem_d[ZeroAddr] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .REG_MEM_ADDR_WIDTH(REG_MEM_ADDR_WIDTH),
    .NUM_RD_PORTS      (NUM_RD_PORTS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_en_i  (rsv_en_i),
    .rsv_addr_i(rsv_addr_i),
    .clr_vec_i (clr_vec),
    .rd_addr_i (rd_addr_i),
    .rd_busy_o (sb_busy),
    .busy_vec_o(busy_vec_o)
  );

  // Entry 0 of mem_q is never written, so x0 reads 0 / not busy naturally.
  always_comb begin
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      rd_data_o[p] = mem_q[rd_addr_i[p]];
      rd_busy_o[p] = sb_busy[p];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is gated by rst_n so reads stay 0 while reset is held.
      for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
        if (rst_n && wr_en_i[w] && (wr_addr_i[w] != ZeroAddr) &&
            (wr_addr_i[w] == rd_addr_i[p])) begin
          rd_data_o[p] = wr_data_i[w];
          rd_busy_o[p] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic [NR-1:0][AW-1:0]   rd_addr;
  logic [NR-1:0][DW-1:0]   rd_data;
  logic [NR-1:0]           rd_busy;
  logic [NW-1:0]           wr_en;
  logic [NW-1:0][AW-1:0]   wr_addr;
  logic [NW-1:0][DW-1:0]   wr_data;
  logic                    rsv_en;
  reg_addr_t               rsv_addr;
  logic [2**AW-1:0]        busy_vec;

  register_file_mp #(
    .DATA_WIDTH        (DW),
    .REG_MEM_ADDR_WIDTH(AW),
    .NUM_RD_PORTS      (NR),
    .NUM_WR_PORTS      (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .rd_busy_o (rd_busy),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .busy_vec_o(busy_vec)
  );

  always #5 clk = ~clk;

  // kind: 0/1 rd_data port, 2/3 rd_busy port, 4 busy_vec
  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      0:       return rd_data[0];
      1:       return rd_data[1];
      2:       return {31'b0, rd_busy[0]};
      3:       return {31'b0, rd_busy[1]};
      default: return busy_vec;
    endcase
  endfunction

  task automatic push(int delay, int kind, logic [31:0] v, string tag);
    exp_t e;
    e.due  = cyc + delay;
    e.kind = kind;
    e.val  = v;
    e.tag  = tag;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t        keep[$];
    logic [31:0] obs;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        obs = observe(q[i].kind);
        checks++;
        assert (obs === q[i].val) else begin
          errors++;
          $error("FAIL %s: observed %h expected %h", q[i].tag, obs, q[i].val);
        end
      end else begin
        keep.push_back(q[i]);
      end
    end
    q = keep;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic settle();
    #1;
    check();
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b1;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    #1;
    // Reset held with writes and a reserve to x5 in flight.
    rst_n      = 1'b0;
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd5;
    wr_en      = 2'b11;
    wr_addr[0] = 5'd5;
    wr_addr[1] = 5'd5;
    wr_data[0] = 32'hDEADBEEF;
    wr_data[1] = 32'hDEADBEEF;
    rsv_en     = 1'b1;
    rsv_addr   = 5'd5;
    step(); push(0, 0, 32'h0, "rst_rd_x5"); push(0, 4, 32'h0, "rst_busy_vec"); settle();
    step(); push(0, 3, 32'h0, "rst_busy_x5"); settle();
    step(); rst_n = 1'b1; idle();
    push(1, 0, 32'h0, "post_rst_x5"); push(1, 4, 32'h0, "post_rst_vec"); settle();
    step(); settle();

    // Basic write/read on x3.
    step();
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h12345678;
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
    push(0, 0, Byp ? 32'h12345678 : 32'h0, "same_cycle_x3");
    push(1, 0, 32'h12345678, "wr_x3_p0"); push(1, 1, 32'h12345678, "wr_x3_p1");
    settle();
    step(); idle(); settle();

    // x0 writes are discarded.
    step();
    wr_en = 2'b10; wr_addr[1] = 5'd0; wr_data[1] = 32'hFFFFFFFF;
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
    push(0, 0, 32'h0, "x0_same"); push(1, 0, 32'h0, "x0_p0"); push(1, 1, 32'h0, "x0_p1");
    push(1, 2, 32'h0, "x0_busy");
    settle();
    step(); idle(); settle();

    // Same-address conflict: port1 wins.
    step();
    wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
    wr_data[0] = 32'h1111; wr_data[1] = 32'h2222;
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
    push(0, 1, Byp ? 32'h2222 : 32'h0, "conflict_same");
    push(1, 0, 32'h2222, "conflict_x7");
    settle();
    step(); idle(); settle();

    // Bypass behaviour on x9.
    step();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'hA5A5A5A5;
    rd_addr[0] = 5'd9;
    push(0, 0, Byp ? 32'hA5A5A5A5 : 32'h0, "bypass_x9_same");
    push(1, 0, 32'hA5A5A5A5, "bypass_x9_next");
    settle();
    step(); idle(); settle();

    // Reserve x4: busy from the next cycle, no same-cycle forwarding.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd4; rd_addr[0] = 5'd4;
    push(0, 2, 32'h0, "rsv_no_fwd");
    push(1, 2, 32'h1, "rsv_x4_busy"); push(1, 4, 32'h10, "rsv_x4_vec");
    settle();
    step(); idle(); settle();

    // Port1 writes x4: busy clears next cycle (masked same cycle with bypass).
    step();
    wr_en = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 32'h44;
    push(0, 2, Byp ? 32'h0 : 32'h1, "wr_x4_busy_same");
    push(0, 4, 32'h10, "wr_x4_vec_same");
    push(1, 2, 32'h0, "wr_clr_busy"); push(1, 4, 32'h0, "wr_clr_vec");
    push(1, 0, 32'h44, "wr_x4_data");
    settle();
    step(); idle(); settle();

    // Reserve and write x4 in the same cycle: reserve wins.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h55;
    push(1, 2, 32'h1, "rsv_wins_busy"); push(1, 4, 32'h10, "rsv_wins_vec");
    push(1, 0, 32'h55, "rsv_wins_data");
    settle();

    // Reserve x0 is ignored.
    step(); idle();
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr[1] = 5'd0;
    push(1, 4, 32'h10, "rsv_x0_vec"); push(1, 3, 32'h0, "rsv_x0_busy");
    settle();

    // Write to a non-busy register: data stored, busy stays 0.
    step(); idle();
    wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'h66; rd_addr[0] = 5'd6;
    push(1, 4, 32'h10, "idle_wr_vec"); push(1, 0, 32'h66, "idle_wr_data");
    push(1, 2, 32'h0, "idle_wr_busy");
    settle();
    step(); idle(); settle();

    // Asynchronous reset mid-stream with a write and reserve in flight.
    step();
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd7;
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hCAFEF00D;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    rst_n = 1'b0;
    #1;
    push(0, 0, 32'h0, "async_rst_x3"); push(0, 1, 32'h0, "async_rst_x7");
    push(0, 4, 32'h0, "async_rst_vec");
    check();
    step();
    step(); rst_n = 1'b1; idle();
    push(1, 0, 32'h0, "post_rst2_x3"); push(1, 1, 32'h0, "post_rst2_x7");
    push(1, 4, 32'h0, "post_rst2_vec");
    settle();
    step(); settle();

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
